// File: rtl/ram32x4_hex_console.sv
// ram32x4_hex_console
//
// Board-level console for a 32-word x 4-bit single-port RAM. Everything runs on
// CLOCK_50; KEY[0] is synchronised and edge-detected into a one-cycle clock
// enable (the "RAM strobe"), and is never used as a clock.
//
// Ports
//   CLOCK_50  in   1  system clock, all flops on its rising edge
//   reset_n   in   1  synchronous active-low reset
//   SW        in  10  SW[9] write enable, SW[8:4] address, SW[3:0] write data
//   KEY       in   4  active-low buttons; KEY[0] is the RAM strobe, KEY[3:1] unused
//   HEX5      out  7  address bit 4 as a hex digit
//   HEX4      out  7  address bits 3:0
//   HEX3      out  7  blank
//   HEX2      out  7  synchronised write data
//   HEX1      out  7  blank
//   HEX0      out  7  RAM output q
//
// Configuration macro
//   RAM_CLEAR_ON_RESET_EN  when defined, reset also zeroes every memory word;
//                          otherwise memory contents survive reset.
//
// There is no handshake and no FSM: the only control is the strobe pulse,
// which advances both RAM stages together or not at all.

module ram32x4_hex_console #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [9:0] SW,
    input  logic [3:0] KEY,
    output logic [6:0] HEX5,
    output logic [6:0] HEX4,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // ---------------- input synchronisers ----------------
    logic [9:0]             sw_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] key_sync;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
            key_sync <= '1;  // idle = released
        end else begin
            sw_sync[0] <= SW;
            for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
            key_sync <= {key_sync[SYNC_STAGES-2:0], KEY[0]};
        end
    end

    logic [9:0]            sw_s;
    logic                  key_s;
    logic                  we_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] data_s;

    assign sw_s   = sw_sync[SYNC_STAGES-1];
    assign key_s  = key_sync[SYNC_STAGES-1];
    assign we_s   = sw_s[9];
    assign addr_s = sw_s[4 +: ADDR_WIDTH];
    assign data_s = sw_s[0 +: DATA_WIDTH];

    logic unused_keys;
    assign unused_keys = ^KEY[3:1];

    // ---------------- strobe: rising edge (release) of KEY[0] ----------------
    // key_prev resets to 1 so the post-reset state never looks like a release.
    logic key_prev;
    logic strobe;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) key_prev <= 1'b1;
        else          key_prev <= key_s;
    end

    assign strobe = key_s & ~key_prev;

    // ---------------- RAM: stage 1 (inputs) and q ----------------
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  we_r;
    logic [DATA_WIDTH-1:0] q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // q samples mem[addr_r] before this strobe's write lands (read-old-data),
    // and stage 1 reloads in the same edge, so stage 2 always uses the old
    // stage-1 contents.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            addr_r <= '0;
            data_r <= '0;
            we_r   <= 1'b0;
            q      <= '0;
        end else if (strobe) begin
            q      <= mem[addr_r];
            addr_r <= addr_s;
            data_r <= data_s;
            we_r   <= we_s;
        end
    end

    // ---------------- RAM: stage 2 (array) ----------------
`ifdef RAM_CLEAR_ON_RESET_EN
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (strobe && we_r) begin
            mem[addr_r] <= data_r;
        end
    end
`else
    // No reset on the array; reset only blocks a write in its own cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset_n && strobe && we_r) mem[addr_r] <= data_r;
    end
`endif

    // ---------------- displays ----------------
    assign HEX5 = hex7({3'b000, addr_s[4]});
    assign HEX4 = hex7(addr_s[3:0]);
    assign HEX3 = 7'b1111111;
    assign HEX2 = hex7(data_s);
    assign HEX1 = 7'b1111111;
    assign HEX0 = hex7(q);

endmodule

// File: tb/tb_ram32x4_hex_console.sv
// Testbench for ram32x4_hex_console: directed steps with a reference model of
// the two-stage strobe-driven RAM; expected HEX0 patterns are queued when each
// strobe is issued and compared after the strobe has taken effect.
module tb_ram32x4_hex_console;

    localparam logic [6:0] BLANK = 7'b1111111;

    // ---------------- clock / reset ----------------
    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic [9:0] SW;
    logic [3:0] KEY;
    logic [6:0] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;

    always #10 CLOCK_50 = ~CLOCK_50;

    ram32x4_hex_console dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .SW       (SW),
        .KEY      (KEY),
        .HEX5     (HEX5),
        .HEX4     (HEX4),
        .HEX3     (HEX3),
        .HEX2     (HEX2),
        .HEX1     (HEX1),
        .HEX0     (HEX0)
    );

    // Segment patterns as listed for the board displays
    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // ---------------- scoreboard / model ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [6:0] exp_q[$];
    bit         chk_q[$];   // 0 = expected word unknown (never written), skip

    logic [3:0] mdl_mem   [32];
    bit         mdl_known [32];
    logic [4:0] m_addr;
    logic [3:0] m_data;
    logic       m_we;

    task automatic cycles(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = '0;
        m_data = '0;
        m_we   = 1'b0;
`ifdef RAM_CLEAR_ON_RESET_EN
        for (int i = 0; i < 32; i++) begin
            mdl_mem[i]   = '0;
            mdl_known[i] = 1'b1;
        end
`endif
    endtask

    // One strobe of the reference: read old word, write, then reload stage 1.
    task automatic model_strobe();
        logic [3:0] old_v;
        bit         old_k;
        old_v = mdl_mem[m_addr];
        old_k = mdl_known[m_addr];
        if (m_we) begin
            mdl_mem[m_addr]   = m_data;
            mdl_known[m_addr] = 1'b1;
        end
        exp_q.push_back(old_k ? seg_tab[old_v] : BLANK);
        chk_q.push_back(old_k);
        m_we   = SW[9];
        m_addr = SW[8:4];
        m_data = SW[3:0];
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycles(3);
        reset_n = 1'b1;
        model_reset();
        cycles(4);
    endtask

    task automatic set_sw(input logic we, input logic [4:0] a, input logic [3:0] d);
        SW = {we, a, d};
        cycles(4);  // longer than the synchroniser chain
    endtask

    // Press and release KEY[0]; the strobe fires on release.
    task automatic strobe(input string tag);
        logic [6:0] e;
        bit         c;
        model_strobe();
        KEY[0] = 1'b0;
        cycles(4);
        KEY[0] = 1'b1;
        cycles(5);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed=%b expected=<empty queue>", tag, HEX0);
        end else begin
            e = exp_q.pop_front();
            c = chk_q.pop_front();
            if (c) check7(tag, HEX0, e);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0] mid_word;
        for (int i = 0; i < 32; i++) begin
            mdl_mem[i]   = '0;
            mdl_known[i] = 1'b0;
        end
        reset_n = 1'b0;
        KEY     = 4'hF;
        SW      = '0;
        cycles(2);
        do_reset();

        // Reset / idle state
        check7("rst_hex5", HEX5, 7'b1000000);
        check7("rst_hex4", HEX4, 7'b1000000);
        check7("rst_hex3", HEX3, BLANK);
        check7("rst_hex2", HEX2, 7'b1000000);
        check7("rst_hex1", HEX1, BLANK);
        check7("rst_hex0", HEX0, 7'b1000000);
        cycles(20);
        check7("idle_hex0", HEX0, 7'b1000000);

        // Write 0xA to 0x0A, 0x5 to 0x02, then read 0x0A
        set_sw(1'b1, 5'h0A, 4'hA); strobe("wr_a_s1");
        set_sw(1'b1, 5'h02, 4'h5); strobe("wr_2_s1");
        set_sw(1'b0, 5'h0A, 4'h0); strobe("rd_a_s1");
        strobe("rd_a_s2");
        check7("rd_0a", HEX0, 7'b0001000);

        // Read 0x02
        set_sw(1'b0, 5'h02, 4'h0); strobe("rd_2_s1");
        strobe("rd_2_s2");
        check7("rd_02", HEX0, 7'b0010010);

        // Switch changes without a strobe
        SW = {1'b1, 5'h15, 4'h7};
        cycles(1);
        check7("sync_hex4_lag", HEX4, 7'b0100100);
        check7("sync_hex2_lag", HEX2, 7'b1000000);
        cycles(1);
        check7("sync_hex5", HEX5, 7'b1111001);
        check7("sync_hex4", HEX4, 7'b0010010);
        check7("sync_hex2", HEX2, 7'b1111000);
        check7("hold_hex0", HEX0, 7'b0010010);
        repeat (20) begin
            SW       = 10'($urandom_range(0, 1023));
            KEY[3:1] = 3'($urandom_range(0, 7));
            cycles(1);
        end
        KEY[3:1] = 3'b111;
        cycles(4);
        check7("hold_rand_hex0", HEX0, 7'b0010010);

        // Read-old-data on address 0x07
        set_sw(1'b1, 5'h07, 4'h5); strobe("rod_s1");
        set_sw(1'b1, 5'h07, 4'h3); strobe("rod_s2");
        set_sw(1'b0, 5'h07, 4'h0); strobe("rod_s3");
        check7("rod_old", HEX0, 7'b0010010);
        strobe("rod_s4");
        check7("rod_new", HEX0, 7'b0110000);

        // Reset between the two strobes of a write to 0x0A
        set_sw(1'b1, 5'h0A, 4'hF); strobe("mid_s1");
        do_reset();
        check7("mid_rst_hex0", HEX0, 7'b1000000);
        set_sw(1'b0, 5'h0A, 4'h0); strobe("mid_s2");
        strobe("mid_s3");
`ifdef RAM_CLEAR_ON_RESET_EN
        mid_word = 4'h0;
`else
        mid_word = 4'hA;
`endif
        check7("mid_word", HEX0, seg_tab[mid_word]);

        // Sweep every address after reset
        for (int a = 0; a < 32; a++) begin
            set_sw(1'b0, 5'(a), 4'h0);
            strobe("sweep");
        end
        strobe("sweep_last");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
